prog_clk_divider: RTL

PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

---
 rtl/clk_div_pkg.sv | 27 ++
 rtl/prog_clk_divider_if.sv | 31 +++
 rtl/clk_div_channel.sv | 69 ++++++
 rtl/prog_clk_divider.sv | 94 +++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants, pending-load record and width helper for the programmable clock divider.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package clk_div_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_HALF  = 3;

    // The pending slot is sized for the largest legal configuration (16 channels,
    // 32-bit counters). The channel field has one spare bit so that any
    // out-of-range target, including 16, can still be recognised.
    localparam int PEND_CH_W   = 5;
    localparam int PEND_HALF_W = 32;

    typedef struct packed {
        logic                   valid;
        logic [PEND_CH_W-1:0]   ch;
        logic [PEND_HALF_W-1:0] half;
    } pend_t;

    // Channel-select width: $clog2(n), but never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Load-request bundle: one new half-period value targeted at one channel.
// Latency: none (wires only).
// Backpressure: valid/ready; a request is taken on an edge where both are high.
interface prog_clk_divider_if
    import clk_div_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int CNT_W = DEF_CNT_W
);
    localparam int CH_W = ch_w(NCH);

    logic             load_valid;
    logic [CH_W-1:0]  load_ch;
    logic [CNT_W-1:0] load_half;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_ch,
        output load_half,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_ch,
        input  load_half,
        output load_ready
    );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, toggling slow clock and a tick strobe.
// Latency: slowclk/tick are registered; a toggle lands on the (half+1)th enabled edge.
// Backpressure: none; a new half value is taken whenever the parent pulses apply.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int RST_HALF = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             align,
    input  logic             apply,
    input  logic [CNT_W-1:0] apply_half,
    output logic             slowclk,
    output logic             tick,
    output logic             term
);

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             slow_q, slow_d;
    logic             tick_q, tick_d;

    // Terminal count of an enabled channel; the parent uses it to time a pending load.
    assign term = en && (cnt_q == half_q);

    // Next-state: disable clears, alignment restarts the period, otherwise count and toggle.
    always_comb begin
        cnt_d  = cnt_q;
        half_d = apply ? apply_half : half_q;
        slow_d = slow_q;
        tick_d = 1'b0;
        if (!en) begin
            cnt_d  = '0;
            slow_d = 1'b0;
        end else if (align) begin
            cnt_d  = '0;
            slow_d = 1'b0;
        end else if (cnt_q == half_q) begin
            // Terminal test comes before the increment, so half = all-ones never overflows.
            cnt_d  = '0;
            slow_d = ~slow_q;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Channel state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            half_q <= CNT_W'(RST_HALF);
            slow_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            slow_q <= slow_d;
            tick_q <= tick_d;
        end
    end

    assign slowclk = slow_q;
    assign tick    = tick_q;

endmodule

// File: rtl/prog_clk_divider.sv
// NCH-channel programmable clock divider with one shared pending-load slot (optional sync phase alignment: CLK_DIV_PHASE_ALIGN_EN).
// Latency: outputs registered; a load takes effect on the target's next terminal edge (next edge if disabled).
// Backpressure: load_ready low while a load is pending; requests are ignored, not queued.
module prog_clk_divider #(
    parameter int NCH      = clk_div_pkg::DEF_NCH,
    parameter int CNT_W    = clk_div_pkg::DEF_CNT_W,
    parameter int DEF_HALF = clk_div_pkg::DEF_HALF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NCH-1:0]           ch_en,
    input  logic                     sync,
    prog_clk_divider_if.slave        load_if,
    output logic [NCH-1:0]           slowclk,
    output logic [NCH-1:0]           tick
);

    import clk_div_pkg::*;

    pend_t            pend_q, pend_d;
    logic [NCH-1:0]   apply;
    logic [NCH-1:0]   term;
    logic             discard;
    logic             sync_eff;
    logic             pend_unused;

`ifdef CLK_DIV_PHASE_ALIGN_EN
    assign sync_eff = sync;
`else
    // Phase alignment is compiled out; the port stays for a uniform pin list.
    logic sync_unused;
    assign sync_unused = sync;
    assign sync_eff    = 1'b0;
`endif

    // Upper bits of the stored half are always zero for narrow counters.
    assign pend_unused = ^pend_q.half;

    // A slot aimed past the last channel is dropped one edge after it was taken.
    assign discard = pend_q.valid && (pend_q.ch >= PEND_CH_W'(NCH));

    // Deliver the pending value only at a period boundary so no half-period is cut short;
    // a stopped channel has no boundary to wait for, and an alignment edge is itself a boundary.
    always_comb begin
        apply = '0;
        for (int i = 0; i < NCH; i++) begin
            apply[i] = pend_q.valid && (pend_q.ch == PEND_CH_W'(i))
                       && (!ch_en[i] || term[i] || sync_eff);
        end
    end

    // Single-entry load slot: free it on delivery or discard, fill it only when it was empty.
    always_comb begin
        pend_d = pend_q;
        if (discard || (|apply)) begin
            pend_d.valid = 1'b0;
        end
        if (!pend_q.valid && load_if.load_valid) begin
            pend_d.valid = 1'b1;
            pend_d.ch    = PEND_CH_W'(load_if.load_ch);
            pend_d.half  = PEND_HALF_W'(load_if.load_half);
        end
    end

    // Pending-slot register; reset discards anything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Ready is a direct flop output: high exactly when the slot is empty.
    assign load_if.load_ready = ~pend_q.valid;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W    (CNT_W),
            .RST_HALF (DEF_HALF)
        ) u_ch (
            .clock      (clock),
            .reset_n    (reset_n),
            .en         (ch_en[g]),
            .align      (sync_eff),
            .apply      (apply[g]),
            .apply_half (pend_q.half[CNT_W-1:0]),
            .slowclk    (slowclk[g]),
            .tick       (tick[g]),
            .term       (term[g])
        );
    end

endmodule
